// File: rtl/mux_select_scanner.sv
// -----------------------------------------------------------------------------
// mux_select_scanner
//
// Scans a 4:1 decoder/tristate mux. It steps the mux select lines through
// channels 0..3, waits SETTLE idle cycles after each select change, samples
// the mux output y_in once per channel and assembles the four samples into a
// 4-bit word. The word is handed off over a valid/ready handshake, either one
// frame per start pulse (CONTINUOUS=0) or back-to-back frames until stop
// (CONTINUOUS=1).
//
// Parameters:
//   SETTLE      idle cycles after each select change before sampling (0..15)
//   CONTINUOUS  0 = one frame per start pulse, 1 = scan until stop
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset, overrides all other inputs
//   start        begin a frame (only looked at while idle)
//   stop         CONTINUOUS=1: finish the current frame, then go idle
//   y_in         mux output y
//   select       channel select toward the mux decoder
//   busy         a frame is in progress
//   data         assembled word, data[i] = y_in sampled while select==i
//   data_valid   data holds an unconsumed word
//   data_ready   consumer accepts data when data_valid && data_ready
//   overrun      sticky: a completed frame overwrote an unconsumed word
//   data_parity  (only with SCAN_PARITY_EN) XOR of the four data bits
//
// Optional feature macro: SCAN_PARITY_EN adds the data_parity output.
// -----------------------------------------------------------------------------
module mux_select_scanner #(
   parameter int SETTLE     = 1,
   parameter int CONTINUOUS = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       y_in,
   output logic [1:0] select,
   output logic       busy,
   output logic [3:0] data,
   output logic       data_valid,
   input  logic       data_ready,
   output logic       overrun
`ifdef SCAN_PARITY_EN
   ,
   output logic       data_parity
`endif
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      SETTLE_WAIT = 2'd1,
      SAMPLE      = 2'd2
   } state_t;

   localparam bit         HAS_SETTLE = (SETTLE > 0);
   localparam bit         CONT       = (CONTINUOUS != 0);
   // Last counter value spent in SETTLE_WAIT; the state lasts exactly SETTLE cycles.
   localparam logic [3:0] CNT_LAST   = HAS_SETTLE ? 4'(SETTLE - 1) : 4'd0;

   state_t     state, state_nxt;
   logic [3:0] cnt;
   logic [2:0] shadow;      // samples of channels 0..2; channel 3 goes straight into data
   logic       stop_seen;
   logic       frame_done;
   logic       keep_going;
   logic [3:0] word_nxt;

   assign busy       = (state != IDLE);
   assign frame_done = (state == SAMPLE) && (select == 2'd3);
   // A stop arriving on the completion edge itself still ends the run.
   assign keep_going = CONT && !stop_seen && !stop;
   assign word_nxt   = {y_in, shadow};

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = HAS_SETTLE ? SETTLE_WAIT : SAMPLE;
         end
         SETTLE_WAIT: begin
            if (cnt == CNT_LAST) state_nxt = SAMPLE;
         end
         SAMPLE: begin
            if (frame_done && !keep_going) state_nxt = IDLE;
            else                           state_nxt = HAS_SETTLE ? SETTLE_WAIT : SAMPLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         select    <= 2'd0;
         shadow    <= 3'd0;
         stop_seen <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state == SETTLE_WAIT && state_nxt == SETTLE_WAIT) cnt <= cnt + 4'd1;
         else                                                 cnt <= 4'd0;

         // select only moves on SAMPLE edges; 3 wraps to 0 for the next frame.
         if (state == SAMPLE) begin
            select <= select + 2'd1;
            if (select != 2'd3) shadow[select] <= y_in;
         end

         if (state_nxt == IDLE)           stop_seen <= 1'b0;
         else if (busy && stop && CONT)   stop_seen <= 1'b1;
      end
   end

   // Output word and handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         data       <= 4'd0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end else if (frame_done) begin
         data       <= word_nxt;
         data_valid <= 1'b1;
         if (data_valid && !data_ready) overrun <= 1'b1;
      end else if (data_valid && data_ready) begin
         data_valid <= 1'b0;
      end
   end

`ifdef SCAN_PARITY_EN
   always_ff @(posedge clk) begin
      if (reset)           data_parity <= 1'b0;
      else if (frame_done) data_parity <= ^word_nxt;
   end
`endif

endmodule
